// File: rtl/indication_output_queue_pkg.sv
// rtl/indication_output_queue_pkg.sv - tag width, tag encoding and entry layout shared by the queue
package indication_output_queue_pkg;

  localparam int TAG_W      = 32;
  localparam int IND_DATA_W = 32;

  typedef logic [TAG_W-1:0] tag_t;

  // Word layout presented on the pipe side at the default field width: {v, meth, tag}.
  typedef struct packed {
    logic [IND_DATA_W-1:0] v;
    logic [IND_DATA_W-1:0] meth;
    tag_t                  tag;
  } ind_entry_t;

  function automatic tag_t encode_tag(input tag_t ch);
    return ch + tag_t'(1);
  endfunction

endpackage

// File: rtl/indication_output_queue_rr_arbiter.sv
// rtl/indication_output_queue_rr_arbiter.sv - round-robin pick among requesting channels
// With no request the grant rests on ptr so the head-of-line channel sees ready.
module rr_arbiter #(
  parameter int NUM_CH = 2,
  parameter int PTR_W  = 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  output logic [PTR_W-1:0]  grant,
  output logic              grant_valid
);

  always_comb begin
    grant       = ptr;
    grant_valid = 1'b0;
    // Walk offsets from farthest to nearest so the channel closest to ptr wins last.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (req[c] && (((int'(ptr) + i) % NUM_CH) == c)) begin
          grant       = PTR_W'(c);
          grant_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/indication_output_queue.sv
// rtl/indication_output_queue.sv - arbitrated indication channels into a circular queue feeding one pipe
// Optional IND_OUT_QUEUE_BYPASS_EN forwards a request straight through when the queue is empty.
module indication_output_queue
  import indication_output_queue_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [NUM_CH-1:0]         indication_heard__ENA,
  input  logic [NUM_CH*DATA_W-1:0]  indication_heard_meth,
  input  logic [NUM_CH*DATA_W-1:0]  indication_heard_v,
  output logic [NUM_CH-1:0]         indication_heard__RDY,
  output logic                      pipe_enq__ENA,
  output logic [2*DATA_W+TAG_W-1:0] pipe_enq_v,
  input  logic                      pipe_enq__RDY
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int EW    = 2 * DATA_W + TAG_W;

  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   grant;
  logic               grant_valid;
  logic [EW-1:0]      mem [DEPTH];

  logic               full;
  logic               empty;
  logic               accept;
  logic               dequeue;
  logic               bypass;
  logic               write_en;
  logic [DATA_W-1:0]  sel_meth;
  logic [DATA_W-1:0]  sel_v;
  logic [EW-1:0]      in_word;

  // The extra wrap bit separates full from empty when the indices coincide.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .PTR_W  (PTR_W)
  ) u_arb (
    .req         (indication_heard__ENA),
    .ptr         (rr_ptr),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  always_comb begin
    sel_meth              = '0;
    sel_v                 = '0;
    indication_heard__RDY = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant == PTR_W'(c)) begin
        sel_meth                 = indication_heard_meth[c*DATA_W +: DATA_W];
        sel_v                    = indication_heard_v[c*DATA_W +: DATA_W];
        indication_heard__RDY[c] = !RST && !full;
      end
    end
  end

  // grant_valid already implies the granted channel is requesting.
  assign accept  = grant_valid && !RST && !full;
  assign in_word = {sel_v, sel_meth, encode_tag(TAG_W'(grant))};
  assign dequeue = !empty && pipe_enq__RDY;

`ifdef IND_OUT_QUEUE_BYPASS_EN
  assign bypass = accept && empty && pipe_enq__RDY;
`else
  assign bypass = 1'b0;
`endif

  assign write_en      = accept && !bypass;
  assign pipe_enq__ENA = dequeue || bypass;
  assign pipe_enq_v    = dequeue ? mem[rd_ptr[AW-1:0]] : (bypass ? in_word : '0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (write_en) begin
        mem[wr_ptr[AW-1:0]] <= in_word;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (dequeue) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
      if (accept) begin
        rr_ptr <= (grant == PTR_W'(NUM_CH - 1)) ? '0 : grant + PTR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_indication_output_queue.sv
// tb/tb_indication_output_queue.sv - vector table, directed corners and randomized model check
module tb_indication_output_queue;

  localparam int NUM_CH = 2;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int EW     = 2 * DATA_W + 32;
`ifdef IND_OUT_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                     CLK = 1'b0;
  logic                     RST;
  logic [NUM_CH-1:0]        ena;
  logic [NUM_CH*DATA_W-1:0] meth;
  logic [NUM_CH*DATA_W-1:0] val;
  logic                     prdy;
  logic [NUM_CH-1:0]        rdy;
  logic                     enq_ena;
  logic [EW-1:0]            enq_v;

  int checks = 0;
  int errors = 0;

  logic [EW-1:0] mq[$];
  int            rr_m = 0;

  typedef struct {
    logic [1:0]    e;
    logic [31:0]   m0, v0, m1, v1;
    logic          pr;
    logic [1:0]    x_rdy;
    logic          x_ena;
    logic [EW-1:0] x_v;
  } vec_t;

  vec_t tbl[$];

  always #5 CLK = ~CLK;

  indication_output_queue #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .CLK                   (CLK),
    .RST                   (RST),
    .indication_heard__ENA (ena),
    .indication_heard_meth (meth),
    .indication_heard_v    (val),
    .indication_heard__RDY (rdy),
    .pipe_enq__ENA         (enq_ena),
    .pipe_enq_v            (enq_v),
    .pipe_enq__RDY         (prdy)
  );

  function automatic logic [EW-1:0] ent(input logic [31:0] v, input logic [31:0] m, input int ch);
    return {v, m, 32'(ch + 1)};
  endfunction

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic int m_winner(input logic [1:0] e);
    for (int k = 0; k < NUM_CH; k++) begin
      int c = (rr_m + k) % NUM_CH;
      if (e[c]) return c;
    end
    return rr_m;
  endfunction

  task automatic model_outputs(output logic [1:0] x_rdy, output logic x_ena, output logic [EW-1:0] x_v);
    int w     = m_winner(ena);
    bit mfull = (mq.size() == DEPTH);
    bit acc   = !mfull && ena[w];
    x_rdy = mfull ? 2'b00 : 2'(1 << w);
    if (mq.size() > 0 && prdy) begin
      x_ena = 1'b1;
      x_v   = mq[0];
    end else if (BYP && acc && prdy) begin
      x_ena = 1'b1;
      x_v   = ent(val[w*DATA_W +: DATA_W], meth[w*DATA_W +: DATA_W], w);
    end else begin
      x_ena = 1'b0;
      x_v   = '0;
    end
  endtask

  task automatic model_advance();
    int            w   = m_winner(ena);
    bit            acc = (mq.size() < DEPTH) && ena[w];
    bit            byp = BYP && acc && (mq.size() == 0) && prdy;
    logic [EW-1:0] nw  = ent(val[w*DATA_W +: DATA_W], meth[w*DATA_W +: DATA_W], w);
    if (mq.size() > 0 && prdy) void'(mq.pop_front());
    if (acc && !byp) mq.push_back(nw);
    if (acc) rr_m = (w + 1) % NUM_CH;
  endtask

  task automatic cycle(input logic [1:0] e, input logic [31:0] m0, input logic [31:0] v0,
                       input logic [31:0] m1, input logic [31:0] v1, input logic pr,
                       input bit use_tbl, input logic [1:0] t_rdy, input logic t_ena,
                       input logic [EW-1:0] t_v, input string name);
    logic [1:0]    x_rdy;
    logic          x_ena;
    logic [EW-1:0] x_v;
    @(negedge CLK);
    ena  = e;
    meth = {m1, m0};
    val  = {v1, v0};
    prdy = pr;
    #2;
    model_outputs(x_rdy, x_ena, x_v);
    if (use_tbl) begin
      x_rdy = t_rdy;
      x_ena = t_ena;
      x_v   = t_v;
    end
    check({name, " rdy"}, EW'(rdy), EW'(x_rdy));
    check({name, " enq_ena"}, EW'(enq_ena), EW'(x_ena));
    check({name, " enq_v"}, enq_v, x_v);
    model_advance();
  endtask

  task automatic reset_pulse(input string name);
    @(negedge CLK);
    RST  = 1'b1;
    ena  = 2'b11;
    prdy = 1'b1;
    mq.delete();
    rr_m = 0;
    #2;
    check({name, " rdy"}, EW'(rdy), '0);
    check({name, " enq_ena"}, EW'(enq_ena), '0);
    check({name, " enq_v"}, enq_v, '0);
    @(negedge CLK);
    RST = 1'b0;
    ena = 2'b00;
  endtask

  task automatic add(input logic [1:0] e, input logic [31:0] m0, input logic [31:0] v0,
                     input logic [31:0] m1, input logic [31:0] v1, input logic pr,
                     input logic [1:0] xr, input logic xe, input logic [EW-1:0] xv);
    vec_t t;
    t.e = e; t.m0 = m0; t.v0 = v0; t.m1 = m1; t.v1 = v1; t.pr = pr;
    t.x_rdy = xr; t.x_ena = xe; t.x_v = xv;
    tbl.push_back(t);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST  = 1'b1;
    ena  = '0;
    meth = '0;
    val  = '0;
    prdy = 1'b0;

    // single send, round-robin alternation, fill to full, full with dequeue, drain
    add(2'b01, 32'h5,  32'hAA,  0,      0,      1, 2'b01, 0, '0);
    add(2'b00, 0,      0,       0,      0,      1, 2'b10, 1, ent(32'hAA, 32'h5, 0));
    add(2'b11, 32'h10, 32'h100, 32'h20, 32'h200, 1, 2'b10, 0, '0);
    add(2'b11, 32'h10, 32'h100, 32'h20, 32'h200, 1, 2'b01, 1, ent(32'h200, 32'h20, 1));
    add(2'b11, 32'h10, 32'h100, 32'h20, 32'h200, 1, 2'b10, 1, ent(32'h100, 32'h10, 0));
    add(2'b00, 0,      0,       0,      0,      1, 2'b01, 1, ent(32'h200, 32'h20, 1));
    add(2'b01, 32'h1,  32'hA1,  0,      0,      0, 2'b01, 0, '0);
    add(2'b01, 32'h2,  32'hA2,  0,      0,      0, 2'b01, 0, '0);
    add(2'b01, 32'h3,  32'hA3,  0,      0,      0, 2'b01, 0, '0);
    add(2'b01, 32'h4,  32'hA4,  0,      0,      0, 2'b01, 0, '0);
    add(2'b01, 32'h5,  32'hA5,  0,      0,      0, 2'b00, 0, '0);
    add(2'b01, 32'h5,  32'hA5,  0,      0,      1, 2'b00, 1, ent(32'hA1, 32'h1, 0));
    add(2'b01, 32'h5,  32'hA5,  0,      0,      1, 2'b01, 1, ent(32'hA2, 32'h2, 0));
    add(2'b00, 0,      0,       0,      0,      1, 2'b10, 1, ent(32'hA3, 32'h3, 0));
    add(2'b00, 0,      0,       0,      0,      1, 2'b10, 1, ent(32'hA4, 32'h4, 0));
    add(2'b00, 0,      0,       0,      0,      1, 2'b10, 1, ent(32'hA5, 32'h5, 0));
    add(2'b00, 0,      0,       0,      0,      1, 2'b10, 0, '0);

    reset_pulse("reset0");

`ifndef IND_OUT_QUEUE_BYPASS_EN
    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].e, tbl[i].m0, tbl[i].v0, tbl[i].m1, tbl[i].v1, tbl[i].pr,
            1'b1, tbl[i].x_rdy, tbl[i].x_ena, tbl[i].x_v, $sformatf("vec%0d", i));
    end
`else
    cycle(2'b10, 0, 0, 32'h0, 32'h7, 1, 1'b1, 2'b10, 1, ent(32'h7, 32'h0, 1), "bypass");
    cycle(2'b00, 0, 0, 0, 0, 1, 1'b1, 2'b01, 0, '0, "bypass_after");
    cycle(2'b10, 0, 0, 32'h1, 32'h8, 0, 1'b1, 2'b10, 0, '0, "bypass_off");
    cycle(2'b00, 0, 0, 0, 0, 1, 1'b1, 2'b01, 1, ent(32'h8, 32'h1, 1), "bypass_off_out");
`endif

    // three entries queued, then reset mid-operation
    for (int i = 0; i < 3; i++) begin
      cycle(2'b01, 32'hB0 + i, 32'hC0 + i, 0, 0, 0, 1'b0, '0, 0, '0, $sformatf("prefill%0d", i));
    end
    reset_pulse("reset_mid");
    cycle(2'b11, 32'hD0, 32'hE0, 32'hD1, 32'hE1, 0, 1'b1, 2'b01, 0, '0, "post_reset_grant");
    cycle(2'b00, 0, 0, 0, 0, 1, 1'b1, 2'b10, 1, ent(32'hE0, 32'hD0, 0), "post_reset_out");
    cycle(2'b00, 0, 0, 0, 0, 1, 1'b1, 2'b10, 0, '0, "post_reset_empty");

    reset_pulse("reset_rand");
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        reset_pulse($sformatf("rand_reset%0d", i));
      end else begin
        cycle(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom,
              ($urandom_range(0, 2) != 0), 1'b0, '0, 0, '0, $sformatf("rand%0d", i));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
